// File: rtl/fifo_pack_pkg.sv
// Shared constants and types for the narrow-to-wide packing FIFO.
// Defaults give a byte write port and a 16-entry, 16-bit-wide store.
package fifo_pack_pkg;

    localparam int DATA_WIDTH_DEF = 8;
    localparam int ADDR_WIDTH_DEF = 4;

    typedef enum logic {
        HALF_LO = 1'b0,
        HALF_HI = 1'b1
    } half_e;

endpackage

// File: rtl/fifo_pack_ctrl.sv
// Pointer/count controller: tracks word pointers, the pending half and the complete-word count.
// Zero latency: flags and lane enables are combinational on registered state.
// Writes are dropped when full unless a read frees a slot in the same cycle; reads on empty are ignored.
module fifo_pack_ctrl
    import fifo_pack_pkg::*;
#(
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr,
    input  logic                  rd,
    output logic                  empty,
    output logic                  full,
    output logic                  half_pending,
    output logic                  w_en_lo,
    output logic                  w_en_hi,
    output logic [ADDR_WIDTH-1:0] w_addr,
    output logic [ADDR_WIDTH-1:0] r_addr
);

    localparam logic [ADDR_WIDTH:0] FULL_CNT = {1'b1, {ADDR_WIDTH{1'b0}}};

    half_e                 w_half;
    logic [ADDR_WIDTH:0]   count;
    logic                  w_acc;
    logic                  r_acc;

    assign empty        = (count == '0);
    assign full         = (count == FULL_CNT) && (w_half == HALF_LO);
    assign half_pending = (w_half == HALF_HI);

    // A read on a full FIFO frees r_addr, which equals w_addr, so the new lower half may land there.
    assign w_acc   = wr & (~full | rd);
    assign r_acc   = rd & ~empty;
    assign w_en_lo = w_acc & (w_half == HALF_LO);
    assign w_en_hi = w_acc & (w_half == HALF_HI);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            w_addr <= '0;
            r_addr <= '0;
            w_half <= HALF_LO;
            count  <= '0;
        end else begin
            if (w_en_lo) begin
                w_half <= HALF_HI;
            end
            if (w_en_hi) begin
                w_half <= HALF_LO;
                w_addr <= w_addr + 1'b1;
            end
            if (r_acc) begin
                r_addr <= r_addr + 1'b1;
            end
            if (w_en_hi && !r_acc) begin
                count <= count + 1'b1;
            end else if (!w_en_hi && r_acc) begin
                count <= count - 1'b1;
            end
        end
    end

endmodule

// File: rtl/reg_file_pack.sv
// Register file of DEPTH double-width words with independently writable lower/upper halves.
// Write takes effect at the clock edge; read is combinational.
// No flow control: the controller only enables lanes it has accepted.
module reg_file_pack #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                    clk,
    input  logic                    w_en_lo,
    input  logic                    w_en_hi,
    input  logic [ADDR_WIDTH-1:0]   w_addr,
    input  logic [DATA_WIDTH-1:0]   w_data,
    input  logic [ADDR_WIDTH-1:0]   r_addr,
    output logic [2*DATA_WIDTH-1:0] r_data
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [2*DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (w_en_lo) begin
            mem[w_addr][DATA_WIDTH-1:0] <= w_data;
        end
        if (w_en_hi) begin
            mem[w_addr][2*DATA_WIDTH-1:DATA_WIDTH] <= w_data;
        end
    end

    assign r_data = mem[r_addr];

endmodule

// File: rtl/fifo_pack.sv
// FWFT FIFO packing pairs of narrow writes into double-width words (earlier item in the low half).
// A word completed at one edge is visible at r_data with empty=0 right after that edge.
// Writes dropped while full without a same-cycle read; reads ignored while empty.
module fifo_pack
    import fifo_pack_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    wr,
    input  logic                    rd,
    input  logic [DATA_WIDTH-1:0]   w_data,
    output logic [2*DATA_WIDTH-1:0] r_data,
    output logic                    empty,
    output logic                    full,
    output logic                    half_pending
);

    logic                  w_en_lo;
    logic                  w_en_hi;
    logic [ADDR_WIDTH-1:0] w_addr;
    logic [ADDR_WIDTH-1:0] r_addr;

    fifo_pack_ctrl #(
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_ctrl (
        .clk         (clk),
        .reset       (reset),
        .wr          (wr),
        .rd          (rd),
        .empty       (empty),
        .full        (full),
        .half_pending(half_pending),
        .w_en_lo     (w_en_lo),
        .w_en_hi     (w_en_hi),
        .w_addr      (w_addr),
        .r_addr      (r_addr)
    );

    reg_file_pack #(
        .DATA_WIDTH(DATA_WIDTH),
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_mem (
        .clk    (clk),
        .w_en_lo(w_en_lo),
        .w_en_hi(w_en_hi),
        .w_addr (w_addr),
        .w_data (w_data),
        .r_addr (r_addr),
        .r_data (r_data)
    );

endmodule

// File: tb/tb_fifo_pack.sv
// Directed bench for fifo_pack with a queue of expected packed words and a popping monitor.
module tb_fifo_pack;

    localparam int DW = 8;
    localparam int AW = 2;

    logic          clk;
    logic          reset;
    logic          wr;
    logic          rd;
    logic [DW-1:0] w_data;
    logic [2*DW-1:0] r_data;
    logic          empty;
    logic          full;
    logic          half_pending;

    int n_checks = 0;
    int n_fail   = 0;
    logic [15:0] exp_q [$];

    fifo_pack #(
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .wr          (wr),
        .rd          (rd),
        .w_data      (w_data),
        .r_data      (r_data),
        .empty       (empty),
        .full        (full),
        .half_pending(half_pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: a pop happens at the next rising edge whenever rd is high and a word is present.
    always @(negedge clk) begin
        if (reset && rd && !empty) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_pop: got 0x%0h expected no word at %0t", r_data, $time);
            end else begin
                chk("pop_data", r_data, exp_q.pop_front());
            end
        end
    end

    // Applies one cycle of inputs starting just after a rising edge; returns just after the next one.
    task automatic cyc(input logic w, input logic r, input logic [DW-1:0] d);
        wr = w;
        rd = r;
        w_data = d;
        @(posedge clk);
        #1;
        wr = 1'b0;
        rd = 1'b0;
    endtask

    task automatic fill_1_to_8();
        for (int i = 1; i <= 8; i++) begin
            if (i % 2 == 0) exp_q.push_back({8'(i), 8'(i - 1)});
            cyc(1'b1, 1'b0, 8'(i));
        end
    endtask

    initial begin
        reset = 1'b0;
        wr = 1'b0;
        rd = 1'b0;
        w_data = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_empty", 16'(empty), 16'd1);
        chk("reset_full", 16'(full), 16'd0);
        chk("reset_half", 16'(half_pending), 16'd0);
        reset = 1'b1;

        // 1: basic pair
        cyc(1'b1, 1'b0, 8'h11);
        chk("t1_half_after_lo", 16'(half_pending), 16'd1);
        chk("t1_empty_after_lo", 16'(empty), 16'd1);
        exp_q.push_back(16'h2211);
        cyc(1'b1, 1'b0, 8'h22);
        chk("t1_empty_after_hi", 16'(empty), 16'd0);
        chk("t1_half_after_hi", 16'(half_pending), 16'd0);
        chk("t1_rdata", r_data, 16'h2211);
        cyc(1'b0, 1'b1, 8'h00);
        chk("t1_empty_after_pop", 16'(empty), 16'd1);

        // 2: fill, drop, drain
        for (int i = 1; i <= 7; i++) begin
            if (i % 2 == 0) exp_q.push_back({8'(i), 8'(i - 1)});
            cyc(1'b1, 1'b0, 8'(i));
        end
        chk("t2_full_at7", 16'(full), 16'd0);
        chk("t2_half_at7", 16'(half_pending), 16'd1);
        exp_q.push_back(16'h0807);
        cyc(1'b1, 1'b0, 8'h08);
        chk("t2_full_at8", 16'(full), 16'd1);
        cyc(1'b1, 1'b0, 8'h09);
        chk("t2_full_after_drop", 16'(full), 16'd1);
        chk("t2_half_after_drop", 16'(half_pending), 16'd0);
        chk("t2_head_after_drop", r_data, 16'h0201);
        repeat (4) cyc(1'b0, 1'b1, 8'h00);
        chk("t2_empty_drained", 16'(empty), 16'd1);

        // 3: read and write together while full
        fill_1_to_8();
        chk("t3_full", 16'(full), 16'd1);
        cyc(1'b1, 1'b1, 8'hAA);
        chk("t3_full_after_rw", 16'(full), 16'd0);
        chk("t3_half_after_rw", 16'(half_pending), 16'd1);
        chk("t3_next_head", r_data, 16'h0403);
        exp_q.push_back(16'hBBAA);
        cyc(1'b1, 1'b0, 8'hBB);
        chk("t3_full_again", 16'(full), 16'd1);
        repeat (4) cyc(1'b0, 1'b1, 8'h00);
        chk("t3_empty_drained", 16'(empty), 16'd1);

        // 4: reset mid-word
        cyc(1'b1, 1'b0, 8'h33);
        chk("t4_half_before_rst", 16'(half_pending), 16'd1);
        #2;
        reset = 1'b0;
        #1;
        chk("t4_empty_in_rst", 16'(empty), 16'd1);
        chk("t4_half_in_rst", 16'(half_pending), 16'd0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        exp_q.push_back(16'h5544);
        cyc(1'b1, 1'b0, 8'h44);
        cyc(1'b1, 1'b0, 8'h55);
        chk("t4_rdata", r_data, 16'h5544);
        cyc(1'b0, 1'b1, 8'h00);

        // 5: underflow attempts
        repeat (3) cyc(1'b0, 1'b1, 8'h00);
        chk("t5_empty", 16'(empty), 16'd1);
        chk("t5_full", 16'(full), 16'd0);
        exp_q.push_back(16'h7766);
        cyc(1'b1, 1'b0, 8'h66);
        cyc(1'b1, 1'b0, 8'h77);
        chk("t5_rdata", r_data, 16'h7766);
        cyc(1'b0, 1'b1, 8'h00);
        chk("t5_empty_after", 16'(empty), 16'd1);

        // 6: streaming through several pointer wraps
        for (int i = 0; i < 40; i++) begin
            logic r;
            r = (i >= 2) && (i % 2 == 0);
            if (i % 2 == 1) exp_q.push_back({8'(8'h80 + i), 8'(8'h80 + i - 1)});
            if (r) chk("t6_no_bubble", 16'(empty), 16'd0);
            cyc(1'b1, r, 8'(8'h80 + i));
        end
        chk("t6_last_present", 16'(empty), 16'd0);
        cyc(1'b0, 1'b1, 8'h00);
        chk("t6_empty_end", 16'(empty), 16'd1);
        chk("t6_queue_drained", 16'(exp_q.size()), 16'd0);

        repeat (2) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
